// File: rtl/nrisc_regfile_pkg.sv
// Shared defaults and address-width helper for the register file, decode and writeback.
package nrisc_regfile_pkg;

  localparam int DEF_TAM   = 16;
  localparam int DEF_NREGS = 16;

  // A one-register file still needs a one-bit address bus.
  function automatic int addr_width(int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/nrisc_regfile_if.sv
// Decode/writeback side of the register file: write port, two read ports, reserve port.
interface nrisc_regfile_if
  import nrisc_regfile_pkg::*;
#(
    parameter int TAM   = DEF_TAM,
    parameter int NREGS = DEF_NREGS
);
    localparam int AW = addr_width(NREGS);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [TAM-1:0]   wdata;
    logic [AW-1:0]    ra0;
    logic [TAM-1:0]   rd0;
    logic [AW-1:0]    ra1;
    logic [TAM-1:0]   rd1;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             busy0;
    logic             busy1;
    logic [NREGS-1:0] pend_vec;

    modport master (
        output we, waddr, wdata, ra0, ra1, rsv_en, rsv_addr,
        input  rd0, rd1, busy0, busy1, pend_vec
    );

    modport slave (
        input  we, waddr, wdata, ra0, ra1, rsv_en, rsv_addr,
        output rd0, rd1, busy0, busy1, pend_vec
    );

endinterface

// File: rtl/nrisc_sb_bit.sv
// One scoreboard pending flop: a reservation outranks a same-cycle writeback clear.
module nrisc_sb_bit (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic pend
);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      pend <= 1'b0;
        else if (set)  pend <= 1'b1;
        else if (clr)  pend <= 1'b0;
    end

endmodule

// File: rtl/nrisc_regfile.sv
// NREGS x TAM register file with write bypass, optional hardwired R0 and a pending scoreboard.
module nrisc_regfile
  import nrisc_regfile_pkg::*;
#(
    parameter int TAM     = DEF_TAM,
    parameter int NREGS   = DEF_NREGS,
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input logic             clk,
    input logic             rst,
    nrisc_regfile_if.slave  bus
);

    localparam int AW = addr_width(NREGS);

    typedef logic [TAM-1:0] word_t;

    word_t            regs [NREGS];
    logic [NREGS-1:0] pend;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (ZERO_R0 && i == 0) begin : g_zero
            assign regs[i] = '0;
            assign pend[i] = 1'b0;
        end else begin : g_live
            word_t q;
            logic  hit_w;
            logic  hit_r;

            assign hit_w = bus.we && (bus.waddr == AW'(i));
            assign hit_r = bus.rsv_en && (bus.rsv_addr == AW'(i));

            // NOTE: every storage word is reset, so this must stay discrete flops rather than a RAM.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)       q <= '0;
                else if (hit_w) q <= bus.wdata;
            end

            assign regs[i] = q;

            nrisc_sb_bit u_sb (
                .clk  (clk),
                .rst  (rst),
                .set  (hit_r),
                .clr  (hit_w),
                .pend (pend[i])
            );
        end
    end

    // Hardwired R0 is applied last so a bypassed write to R0 can never leak out.
    // NOTE: each output gets its default first, so no path through the block leaves a latch.
    always_comb begin
        bus.rd0 = regs[bus.ra0];
        bus.rd1 = regs[bus.ra1];
        if (BYPASS && bus.we) begin
            if (bus.waddr == bus.ra0) bus.rd0 = bus.wdata;
            if (bus.waddr == bus.ra1) bus.rd1 = bus.wdata;
        end
        if (ZERO_R0) begin
            if (bus.ra0 == '0) bus.rd0 = '0;
            if (bus.ra1 == '0) bus.rd1 = '0;
        end
    end

    // Busy reflects registered state only; a same-cycle write does not hide it.
    assign bus.busy0    = pend[bus.ra0];
    assign bus.busy1    = pend[bus.ra1];
    assign bus.pend_vec = pend;

endmodule
